// File: rtl/pipe_pkg.sv
// Shared constants for the writeback skid buffer: control-bit layout and
// occupancy state encoding.
package pipe_pkg;

    localparam int CTRL_W = 7;

    // Bit positions inside the writeback control vector.
    localparam int CTRL_ZERO     = 0;
    localparam int CTRL_NEG      = 1;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_JUMP     = 3;
    localparam int CTRL_BTYPE    = 4;
    localparam int CTRL_BRANCH   = 5;
    localparam int CTRL_REGWRT   = 6;

    // The state value doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/pipe_entry.sv
// One buffer slot: a valid bit plus payload registers. Clear drops only the
// valid bit so the payload keeps its last value.
module pipe_entry #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 6,
    parameter int CTRL_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] new_ctrl,
    input  logic [DATA_W-1:0] new_aluresult,
    input  logic [DATA_W-1:0] new_memdata,
    input  logic [RD_W-1:0]   new_rd,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] aluresult,
    output logic [DATA_W-1:0] memdata,
    output logic [RD_W-1:0]   rd
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid     <= 1'b0;
            ctrl      <= '0;
            aluresult <= '0;
            memdata   <= '0;
            rd        <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid     <= 1'b1;
            ctrl      <= new_ctrl;
            aluresult <= new_aluresult;
            memdata   <= new_memdata;
            rd        <= new_rd;
        end
    end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer between pipeline stages: full throughput, with
// in_ready taken only from registered state.
module pipe_skid_buffer
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_W   = 6,
    parameter int CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_aluresult,
    input  logic [DATA_W-1:0] in_memdata,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_aluresult,
    output logic [DATA_W-1:0] out_memdata,
    output logic [RD_W-1:0]   out_rd,
    output logic [1:0]        occupancy
);

    logic [1:0] state, state_nxt;
    logic       accept, pop;
    logic       main_load, main_clear, main_from_skid;
    logic       skid_load, skid_clear;

    logic              main_valid, skid_valid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_new_ctrl;
    logic [DATA_W-1:0] main_alu, skid_alu, main_new_alu;
    logic [DATA_W-1:0] main_mem, skid_mem, main_new_mem;
    logic [RD_W-1:0]   main_rd, skid_rd, main_new_rd;

    assign in_ready  = (state != ST_FULL);
    assign accept    = in_valid && in_ready;
    assign pop       = main_valid && out_ready;
    assign occupancy = state;

    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
            state_nxt  = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) begin
                    main_load = 1'b1;
                    state_nxt = ST_ONE;
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_nxt = ST_FULL;
                    end else if (pop) begin
                        main_clear = 1'b1;
                        state_nxt  = ST_EMPTY;
                    end
                end
                ST_FULL: if (pop) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clear     = 1'b1;
                    state_nxt      = ST_ONE;
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                    state_nxt  = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    // Draining FULL refills the head from the skid slot, otherwise from upstream.
    always_comb begin
        main_new_ctrl = in_ctrl;
        main_new_alu  = in_aluresult;
        main_new_mem  = in_memdata;
        main_new_rd   = in_rd;
        if (main_from_skid) begin
            main_new_ctrl = skid_ctrl;
            main_new_alu  = skid_alu;
            main_new_mem  = skid_mem;
            main_new_rd   = skid_rd;
        end
    end

    pipe_entry #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) u_main (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (main_load),
        .clear         (main_clear),
        .new_ctrl      (main_new_ctrl),
        .new_aluresult (main_new_alu),
        .new_memdata   (main_new_mem),
        .new_rd        (main_new_rd),
        .valid         (main_valid),
        .ctrl          (main_ctrl),
        .aluresult     (main_alu),
        .memdata       (main_mem),
        .rd            (main_rd)
    );

    pipe_entry #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) u_skid (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (skid_load),
        .clear         (skid_clear),
        .new_ctrl      (in_ctrl),
        .new_aluresult (in_aluresult),
        .new_memdata   (in_memdata),
        .new_rd        (in_rd),
        .valid         (skid_valid),
        .ctrl          (skid_ctrl),
        .aluresult     (skid_alu),
        .memdata       (skid_mem),
        .rd            (skid_rd)
    );

    // A bubble must never carry write or branch controls downstream.
    assign out_valid     = main_valid;
    assign out_ctrl      = main_valid ? main_ctrl : '0;
    assign out_aluresult = main_alu;
    assign out_memdata   = main_mem;
    assign out_rd        = main_rd;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer: directed reset/stream sequences,
// a vector table for stall/flush corners, and a queue-model random run.
module tb_pipe_skid_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_ctrl;
    logic [31:0] in_aluresult;
    logic [31:0] in_memdata;
    logic [5:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_ctrl;
    logic [31:0] out_aluresult;
    logic [31:0] out_memdata;
    logic [5:0]  out_rd;
    logic [1:0]  occupancy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_skid_buffer #(.DATA_W(32), .RD_W(6), .CTRL_W(7)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_ctrl       (in_ctrl),
        .in_aluresult  (in_aluresult),
        .in_memdata    (in_memdata),
        .in_rd         (in_rd),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ctrl      (out_ctrl),
        .out_aluresult (out_aluresult),
        .out_memdata   (out_memdata),
        .out_rd        (out_rd),
        .occupancy     (occupancy)
    );

    typedef struct {
        logic       iv;
        logic       ordy;
        logic       fl;
        logic [5:0] rd;
        logic [6:0] ctrl;
        logic       e_ov;
        logic [5:0] e_rd;
        logic [1:0] e_occ;
        logic       e_ir;
        logic [6:0] e_ctrl;
    } vec_t;

    typedef struct packed {
        logic [6:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [5:0]  rd;
    } ent_t;

    vec_t tbl [11];
    ent_t q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic       last_acc;
        logic       ir0;
        logic       m_ir;
        ent_t       cur;

        // Reset asserted with an entry offered: nothing may get through.
        rst_n        = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b1;
        in_ctrl      = 7'h7F;
        in_aluresult = 32'h0000_0005;
        in_memdata   = 32'h0;
        in_rd        = 6'd1;
        out_ready    = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(1'b0));
        check("rst_out_ctrl",  32'(out_ctrl),  32'(7'h0));
        check("rst_occupancy", 32'(occupancy), 32'(2'd0));
        check("rst_in_ready",  32'(in_ready),  32'(1'b1));
        tick();
        check("rst_hold_valid", 32'(out_valid), 32'(1'b0));
        rst_n = 1'b1;
        tick();
        check("first_valid", 32'(out_valid),     32'(1'b1));
        check("first_alu",   32'(out_aluresult), 32'h5);
        check("first_occ",   32'(occupancy),     32'(2'd1));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("drain_occ", 32'(occupancy), 32'(2'd0));

        // Streaming at full rate: each entry appears one cycle after it is offered.
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_rd    = 6'(k);
            in_ctrl  = 7'h01;
            check("stream_in_ready", 32'(in_ready), 32'(1'b1));
            tick();
            check("stream_valid", 32'(out_valid), 32'(1'b1));
            check("stream_rd",    32'(out_rd),    32'(k));
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_occ", 32'(occupancy), 32'(2'd0));

        // Stall, skid, hold-upstream and flush corners.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 6'd3,  7'h41, 1'b1, 6'd3,  2'd1, 1'b1, 7'h41};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 6'd4,  7'h41, 1'b1, 6'd3,  2'd2, 1'b0, 7'h41};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 6'd5,  7'h41, 1'b1, 6'd3,  2'd2, 1'b0, 7'h41};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 6'd5,  7'h41, 1'b1, 6'd4,  2'd1, 1'b1, 7'h41};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 6'd5,  7'h41, 1'b1, 6'd5,  2'd1, 1'b1, 7'h41};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 6'd5,  7'h41, 1'b0, 6'd5,  2'd0, 1'b1, 7'h00};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 6'd9,  7'h7F, 1'b1, 6'd9,  2'd1, 1'b1, 7'h7F};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 6'd10, 7'h7F, 1'b1, 6'd9,  2'd2, 1'b0, 7'h7F};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 6'd11, 7'h7F, 1'b0, 6'd9,  2'd0, 1'b1, 7'h00};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 6'd12, 7'h7F, 1'b1, 6'd12, 2'd1, 1'b1, 7'h7F};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 6'd12, 7'h7F, 1'b0, 6'd12, 2'd0, 1'b1, 7'h00};
        for (int i = 0; i < 11; i++) begin
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            flush     = tbl[i].fl;
            in_rd     = tbl[i].rd;
            in_ctrl   = tbl[i].ctrl;
            tick();
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            check($sformatf("vec%0d_rd", i),    32'(out_rd),    32'(tbl[i].e_rd));
            check($sformatf("vec%0d_occ", i),   32'(occupancy), 32'(tbl[i].e_occ));
            check($sformatf("vec%0d_ready", i), 32'(in_ready),  32'(tbl[i].e_ir));
            check($sformatf("vec%0d_ctrl", i),  32'(out_ctrl),  32'(tbl[i].e_ctrl));
        end
        flush = 1'b0;

        // Random traffic against an in-order queue model of capacity two.
        q.delete();
        last_acc = 1'b1;
        in_valid = 1'b0;
        cur      = '0;
        for (int c = 0; c < 10000; c++) begin
            if (!in_valid || last_acc) begin
                cur.ctrl = 7'($urandom);
                cur.alu  = $urandom;
                cur.mem  = $urandom;
                cur.rd   = 6'($urandom);
                in_valid = ($urandom % 4) != 0;
            end
            in_ctrl      = cur.ctrl;
            in_aluresult = cur.alu;
            in_memdata   = cur.mem;
            in_rd        = cur.rd;
            out_ready    = ($urandom % 3) != 0;
            flush        = ($urandom % 64) == 0;
            if (c % 8 == 0) begin
                ir0       = in_ready;
                out_ready = ~out_ready;
                #1;
                check("ready_indep", 32'(in_ready), 32'(ir0));
                out_ready = ~out_ready;
                #1;
            end
            @(posedge clk);
            m_ir     = (q.size() < 2);
            last_acc = flush || (in_valid && m_ir);
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (in_valid && m_ir) q.push_back(cur);
            end
            @(negedge clk);
            check("rnd_valid", 32'(out_valid), 32'(q.size() > 0));
            check("rnd_occ",   32'(occupancy), 32'(q.size()));
            check("rnd_ready", 32'(in_ready),  32'(q.size() < 2));
            if (q.size() > 0) begin
                check("rnd_ctrl", 32'(out_ctrl),    32'(q[0].ctrl));
                check("rnd_alu",  out_aluresult,     q[0].alu);
                check("rnd_mem",  out_memdata,       q[0].mem);
                check("rnd_rd",   32'(out_rd),       32'(q[0].rd));
            end else begin
                check("rnd_bubble_ctrl", 32'(out_ctrl), 32'(7'h0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
